// File: rtl/ddrx_mon_pkg.sv
// Shared types and helpers for the DDR edge-window monitor.
package ddrx_mon_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } lane_state_t;

  // All-ones value of a w-bit field; marks a lane that never saw its edge.
  function automatic logic [31:0] sentinel(input int w);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/ddrx_edge_window_ch.sv
// One monitored lane: measures cycles from a reference edge to the lane edge
// and classifies the delay against the inclusive [win_min, win_max] window.
module ddrx_edge_window_ch
  import ddrx_mon_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             i_ck,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_cfg_err,
  input  logic             i_ref_edge,
  input  logic             i_sig_edge,
  input  logic [CNT_W-1:0] i_win_min,
  input  logic [CNT_W-1:0] i_win_max,
  output logic             o_early,
  output logic             o_late,
  output logic             o_meas_valid,
  output logic [CNT_W-1:0] o_last_delay,
  output lane_state_t      o_state
);

  localparam logic [CNT_W-1:0] SENT = CNT_W'(sentinel(CNT_W));

  lane_state_t      r_state;
  lane_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_delay;
  logic             w_done;
  logic             w_abort;

  // w_done: a real delay was measured. w_abort: the lane gave up late
  // (timeout, or a new reference edge arrived first) and reports the sentinel.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_delay     = r_cnt;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    if (!i_en) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_ref_edge && !i_cfg_err) begin
            if (i_sig_edge) begin
              w_done  = 1'b1;
              w_delay = '0;
            end else begin
              w_state_nxt = ST_ARMED;
              w_cnt_nxt   = CNT_W'(1);
            end
          end
        end
        ST_ARMED: begin
          if (i_sig_edge || i_ref_edge) begin
            w_done  = i_sig_edge;
            w_abort = !i_sig_edge;
            if (i_ref_edge && !i_cfg_err) begin
              w_state_nxt = ST_ARMED;
              w_cnt_nxt   = CNT_W'(1);
            end else begin
              w_state_nxt = ST_IDLE;
              w_cnt_nxt   = '0;
            end
          end else if (r_cnt == i_win_max) begin
            w_abort     = 1'b1;
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Violations are decided this cycle so the top can register them together
  // with meas_valid.
  assign o_early = w_done && (w_delay < i_win_min);
  assign o_late  = w_abort || (w_done && (w_delay > i_win_max));
  assign o_state = r_state;

  always_ff @(posedge i_ck or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      o_meas_valid <= 1'b0;
      o_last_delay <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      o_meas_valid <= w_done || w_abort;
      if (w_done) begin
        o_last_delay <= w_delay;
      end else if (w_abort) begin
        o_last_delay <= SENT;
      end
    end
  end

endmodule

// File: rtl/ddrx_edge_window_mon.sv
// Multi-lane DDR edge-window monitor: per-lane delay measurement plus shared
// window check, sticky violation flags and a saturating violation counter.
module ddrx_edge_window_mon
  import ddrx_mon_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 8,
  parameter int VIOL_W = 16
) (
  input  logic                    ck,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    clr,
  input  logic                    ref_edge,
  input  logic [NUM_CH-1:0]       sig_edge,
  input  logic [CNT_W-1:0]        win_min,
  input  logic [CNT_W-1:0]        win_max,
  output logic [NUM_CH-1:0]       meas_valid,
  output logic [NUM_CH*CNT_W-1:0] last_delay,
  output logic [NUM_CH-1:0]       viol_early,
  output logic [NUM_CH-1:0]       viol_late,
  output logic [VIOL_W-1:0]       viol_cnt,
  output logic                    cfg_err,
  output logic [NUM_CH-1:0]       dbg_lane_armed
);

  localparam int               PW   = $clog2(NUM_CH + 1);
  localparam logic [CNT_W-1:0] SENT = CNT_W'(sentinel(CNT_W));

  logic                r_cfg_err;
  logic [NUM_CH-1:0]   r_viol_early;
  logic [NUM_CH-1:0]   r_viol_late;
  logic [VIOL_W-1:0]   r_viol_cnt;
  logic [NUM_CH-1:0]   w_early;
  logic [NUM_CH-1:0]   w_late;
  logic [PW-1:0]       w_pop;
  logic [VIOL_W:0]     w_sum;
  logic [VIOL_W-1:0]   w_cnt_nxt;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    lane_state_t w_state;
    ddrx_edge_window_ch #(.CNT_W(CNT_W)) u_ch (
      .i_ck         (ck),
      .i_rst_n      (rst_n),
      .i_en         (en),
      .i_cfg_err    (r_cfg_err),
      .i_ref_edge   (ref_edge),
      .i_sig_edge   (sig_edge[g]),
      .i_win_min    (win_min),
      .i_win_max    (win_max),
      .o_early      (w_early[g]),
      .o_late       (w_late[g]),
      .o_meas_valid (meas_valid[g]),
      .o_last_delay (last_delay[g*CNT_W +: CNT_W]),
      .o_state      (w_state)
    );
    assign dbg_lane_armed[g] = (w_state == ST_ARMED);
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_pop = w_pop + PW'(w_early[i] | w_late[i]);
    end
    w_sum     = {1'b0, r_viol_cnt} + (VIOL_W+1)'(w_pop);
    w_cnt_nxt = w_sum[VIOL_W] ? '1 : w_sum[VIOL_W-1:0];
  end

  // Clear takes priority over violations landing in the same cycle.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_err    <= 1'b0;
      r_viol_early <= '0;
      r_viol_late  <= '0;
      r_viol_cnt   <= '0;
    end else begin
      r_cfg_err <= (win_min > win_max) || (win_max == SENT);
      if (clr) begin
        r_viol_early <= '0;
        r_viol_late  <= '0;
        r_viol_cnt   <= '0;
      end else begin
        r_viol_early <= r_viol_early | w_early;
        r_viol_late  <= r_viol_late | w_late;
        r_viol_cnt   <= w_cnt_nxt;
      end
    end
  end

  assign cfg_err    = r_cfg_err;
  assign viol_early = r_viol_early;
  assign viol_late  = r_viol_late;
  assign viol_cnt   = r_viol_cnt;

endmodule

// File: tb/tb_ddrx_edge_window_mon.sv
// Bench for ddrx_edge_window_mon: directed vector table, timestamp-based
// reference model under random stimulus, reset and saturation sequences.
module tb_ddrx_edge_window_mon;

  localparam int NUM_CH = 8;
  localparam int CNT_W  = 8;
  localparam int VIOL_W = 16;
  localparam longint CNT_MAX = (64'd1 << VIOL_W) - 1;

  logic                    ck = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    en = 1'b0;
  logic                    clr = 1'b0;
  logic                    ref_edge = 1'b0;
  logic [NUM_CH-1:0]       sig_edge = '0;
  logic [CNT_W-1:0]        win_min = 8'd3;
  logic [CNT_W-1:0]        win_max = 8'd5;
  logic [NUM_CH-1:0]       meas_valid;
  logic [NUM_CH*CNT_W-1:0] last_delay;
  logic [NUM_CH-1:0]       viol_early;
  logic [NUM_CH-1:0]       viol_late;
  logic [VIOL_W-1:0]       viol_cnt;
  logic                    cfg_err;
  logic [NUM_CH-1:0]       dbg_lane_armed;

  ddrx_edge_window_mon #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .VIOL_W(VIOL_W)) dut (
    .ck             (ck),
    .rst_n          (rst_n),
    .en             (en),
    .clr            (clr),
    .ref_edge       (ref_edge),
    .sig_edge       (sig_edge),
    .win_min        (win_min),
    .win_max        (win_max),
    .meas_valid     (meas_valid),
    .last_delay     (last_delay),
    .viol_early     (viol_early),
    .viol_late      (viol_late),
    .viol_cnt       (viol_cnt),
    .cfg_err        (cfg_err),
    .dbg_lane_armed (dbg_lane_armed)
  );

  // ---------------- clock ----------------
  always #5 ck = ~ck;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each lane remembers the cycle number at which it was armed; the delay is
  // simply the elapsed cycle count.
  bit              m_armed [NUM_CH];
  longint          m_arm   [NUM_CH];
  longint          m_cyc;
  logic [7:0]      e_mv, e_early, e_late;
  logic [63:0]     e_ld;
  longint          e_cnt;
  logic            e_cfg;

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_armed[i] = 0;
      m_arm[i]   = 0;
    end
    m_cyc = 0; e_mv = '0; e_early = '0; e_late = '0; e_ld = '0; e_cnt = 0; e_cfg = 1'b0;
  endtask

  task automatic model_step();
    logic [7:0] ne, nl, mv;
    ne = '0; nl = '0; mv = '0;
    m_cyc++;
    for (int i = 0; i < NUM_CH; i++) begin
      int     kind;
      longint d;
      kind = 0;
      d    = 0;
      if (!en) begin
        m_armed[i] = 0;
      end else if (!m_armed[i]) begin
        if (ref_edge && !e_cfg) begin
          if (sig_edge[i]) kind = 1;
          else begin
            m_armed[i] = 1;
            m_arm[i]   = m_cyc;
          end
        end
      end else begin
        d = m_cyc - m_arm[i];
        if (sig_edge[i] || ref_edge) begin
          kind       = sig_edge[i] ? 1 : 2;
          m_armed[i] = ref_edge && !e_cfg;
          m_arm[i]   = m_cyc;
        end else if (d == longint'(win_max)) begin
          kind       = 2;
          m_armed[i] = 0;
        end
      end
      if (kind == 1) begin
        mv[i] = 1'b1;
        e_ld[i*8 +: 8] = 8'(d);
        if (d < longint'(win_min)) ne[i] = 1'b1;
        if (d > longint'(win_max)) nl[i] = 1'b1;
      end else if (kind == 2) begin
        mv[i] = 1'b1;
        e_ld[i*8 +: 8] = 8'hFF;
        nl[i] = 1'b1;
      end
    end
    e_mv  = mv;
    e_cfg = (win_min > win_max) || (win_max == 8'hFF);
    if (clr) begin
      e_early = '0; e_late = '0; e_cnt = 0;
    end else begin
      e_early = e_early | ne;
      e_late  = e_late | nl;
      e_cnt   = e_cnt + $countones(ne | nl);
      if (e_cnt > CNT_MAX) e_cnt = CNT_MAX;
    end
  endtask

  task automatic check_model();
    check("m_mv",    64'(meas_valid), 64'(e_mv));
    check("m_ld",    last_delay,      e_ld);
    check("m_early", 64'(viol_early), 64'(e_early));
    check("m_late",  64'(viol_late),  64'(e_late));
    check("m_vcnt",  64'(viol_cnt),   64'(e_cnt));
    check("m_cfg",   64'(cfg_err),    64'(e_cfg));
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic [7:0] s, input logic e, input logic c,
                      input logic [7:0] wmn, input logic [7:0] wmx);
    ref_edge = r; sig_edge = s; en = e; clr = c; win_min = wmn; win_max = wmx;
    @(posedge ck);
    model_step();
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mv"},    64'(meas_valid),     64'd0);
    check({tag, "_ld"},    last_delay,          64'd0);
    check({tag, "_early"}, 64'(viol_early),     64'd0);
    check({tag, "_late"},  64'(viol_late),      64'd0);
    check({tag, "_vcnt"},  64'(viol_cnt),       64'd0);
    check({tag, "_cfg"},   64'(cfg_err),        64'd0);
    check({tag, "_armed"}, 64'(dbg_lane_armed), 64'd0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        r;
    logic [7:0]  s;
    logic        e;
    logic        c;
    logic [7:0]  wmn;
    logic [7:0]  wmx;
    logic [7:0]  x_mv;
    logic [7:0]  x_early;
    logic [7:0]  x_late;
    logic [15:0] x_cnt;
    logic        x_cfg;
    logic [7:0]  x_ld0;
    logic [7:0]  x_ld1;
    logic [7:0]  x_ld2;
  } vec_t;

  vec_t tbl [22];

  initial begin
    // ref at row 0; lane 2 early at +1, lane 0 on time at +4, the rest time out at +5
    tbl[0]  = '{1'b1, 8'h00, 1'b1, 1'b0, 8'd3, 8'd5,   8'h00, 8'h00, 8'h00, 16'd0, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[1]  = '{1'b0, 8'h04, 1'b1, 1'b0, 8'd3, 8'd5,   8'h04, 8'h04, 8'h00, 16'd1, 1'b0, 8'h00, 8'h00, 8'h01};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'd3, 8'd5,   8'h00, 8'h04, 8'h00, 16'd1, 1'b0, 8'h00, 8'h00, 8'h01};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'd3, 8'd5,   8'h00, 8'h04, 8'h00, 16'd1, 1'b0, 8'h00, 8'h00, 8'h01};
    tbl[4]  = '{1'b0, 8'h01, 1'b1, 1'b0, 8'd3, 8'd5,   8'h01, 8'h04, 8'h00, 16'd1, 1'b0, 8'h04, 8'h00, 8'h01};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'd3, 8'd5,   8'hFA, 8'h04, 8'hFA, 16'd7, 1'b0, 8'h04, 8'hFF, 8'h01};
    tbl[6]  = '{1'b0, 8'hFF, 1'b1, 1'b0, 8'd3, 8'd5,   8'h00, 8'h04, 8'hFA, 16'd7, 1'b0, 8'h04, 8'hFF, 8'h01};
    tbl[7]  = '{1'b1, 8'h01, 1'b1, 1'b0, 8'd3, 8'd5,   8'h01, 8'h05, 8'hFA, 16'd8, 1'b0, 8'h00, 8'hFF, 8'h01};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'd3, 8'd5,   8'h00, 8'h00, 8'h00, 16'd0, 1'b0, 8'h00, 8'hFF, 8'h01};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'd3, 8'd5,   8'h00, 8'h00, 8'h00, 16'd0, 1'b0, 8'h00, 8'hFF, 8'h01};
    tbl[10] = '{1'b1, 8'h00, 1'b1, 1'b0, 8'd3, 8'd5,   8'h00, 8'h00, 8'h00, 16'd0, 1'b0, 8'h00, 8'hFF, 8'h01};
    tbl[11] = '{1'b1, 8'h00, 1'b1, 1'b0, 8'd3, 8'd5,   8'hFF, 8'h00, 8'hFF, 16'd8, 1'b0, 8'hFF, 8'hFF, 8'hFF};
    tbl[12] = '{1'b1, 8'h00, 1'b1, 1'b1, 8'd3, 8'd5,   8'hFF, 8'h00, 8'h00, 16'd0, 1'b0, 8'hFF, 8'hFF, 8'hFF};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'd3, 8'd5,   8'h00, 8'h00, 8'h00, 16'd0, 1'b0, 8'hFF, 8'hFF, 8'hFF};
    // inverted window: cfg_err rises, reference edges ignored
    tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'd6, 8'd2,   8'h00, 8'h00, 8'h00, 16'd0, 1'b1, 8'hFF, 8'hFF, 8'hFF};
    tbl[15] = '{1'b1, 8'h00, 1'b1, 1'b0, 8'd6, 8'd2,   8'h00, 8'h00, 8'h00, 16'd0, 1'b1, 8'hFF, 8'hFF, 8'hFF};
    tbl[16] = '{1'b0, 8'h01, 1'b1, 1'b0, 8'd6, 8'd2,   8'h00, 8'h00, 8'h00, 16'd0, 1'b1, 8'hFF, 8'hFF, 8'hFF};
    tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'd3, 8'd5,   8'h00, 8'h00, 8'h00, 16'd0, 1'b0, 8'hFF, 8'hFF, 8'hFF};
    tbl[18] = '{1'b1, 8'h00, 1'b1, 1'b0, 8'd3, 8'd5,   8'h00, 8'h00, 8'h00, 16'd0, 1'b0, 8'hFF, 8'hFF, 8'hFF};
    tbl[19] = '{1'b0, 8'hFF, 1'b1, 1'b0, 8'd3, 8'd5,   8'hFF, 8'hFF, 8'h00, 16'd8, 1'b0, 8'h01, 8'h01, 8'h01};
    // win_max at all-ones is illegal, one below is legal
    tbl[20] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'd0, 8'hFF,  8'h00, 8'hFF, 8'h00, 16'd8, 1'b1, 8'h01, 8'h01, 8'h01};
    tbl[21] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'd0, 8'hFE,  8'h00, 8'hFF, 8'h00, 16'd8, 1'b0, 8'h01, 8'h01, 8'h01};
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] wmn, wmx, s;
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge ck);
    #1;
    check_all_zero("rst");
    #3 rst_n = 1'b1;

    for (int k = 0; k < 22; k++) begin
      step(tbl[k].r, tbl[k].s, tbl[k].e, tbl[k].c, tbl[k].wmn, tbl[k].wmx);
      check($sformatf("v%0d_mv", k),    64'(meas_valid),        64'(tbl[k].x_mv));
      check($sformatf("v%0d_early", k), 64'(viol_early),        64'(tbl[k].x_early));
      check($sformatf("v%0d_late", k),  64'(viol_late),         64'(tbl[k].x_late));
      check($sformatf("v%0d_vcnt", k),  64'(viol_cnt),          64'(tbl[k].x_cnt));
      check($sformatf("v%0d_cfg", k),   64'(cfg_err),           64'(tbl[k].x_cfg));
      check($sformatf("v%0d_ld0", k),   64'(last_delay[7:0]),   64'(tbl[k].x_ld0));
      check($sformatf("v%0d_ld1", k),   64'(last_delay[15:8]),  64'(tbl[k].x_ld1));
      check($sformatf("v%0d_ld2", k),   64'(last_delay[23:16]), 64'(tbl[k].x_ld2));
    end

    // random traffic; the window only changes in cycles with en=0
    wmn = 8'd3; wmx = 8'd5;
    for (int k = 0; k < 1500; k++) begin
      if (k % 40 == 0) begin
        wmn = 8'($urandom_range(0, 6));
        wmx = 8'($urandom_range(1, 12));
        if ($urandom_range(0, 5) == 0) wmx = 8'hFF;
        step(1'b0, 8'h00, 1'b0, 1'b0, wmn, wmx);
      end else begin
        for (int i = 0; i < NUM_CH; i++) s[i] = ($urandom_range(0, 4) == 0);
        step($urandom_range(0, 5) == 0, s, $urandom_range(0, 63) != 0,
             $urandom_range(0, 99) == 0, wmn, wmx);
      end
      check_model();
    end

    // reset in the middle of an armed measurement
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'd3, 8'd5);
    step(1'b1, 8'h00, 1'b1, 1'b0, 8'd3, 8'd5);
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'd3, 8'd5);
    check("pre_rst_armed", 64'(dbg_lane_armed), 64'hFF);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("mid_rst");
    #2 rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 8'd3, 8'd5);
      check("post_rst_mv", 64'(meas_valid), 64'd0);
      check("post_rst_late", 64'(viol_late), 64'd0);
      check_model();
    end

    // drive viol_cnt up to 16'hFFFA, then saturate with all lanes late
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'd0, 8'd5);
    step(1'b1, 8'h00, 1'b1, 1'b0, 8'd0, 8'd5);
    for (int k = 0; k < 8191; k++) step(1'b1, 8'h00, 1'b1, 1'b0, 8'd0, 8'd5);
    check("sat_65528", 64'(viol_cnt), 64'd65528);
    check_model();
    step(1'b1, 8'hFC, 1'b1, 1'b0, 8'd0, 8'd5);
    check("sat_fffa", 64'(viol_cnt), 64'hFFFA);
    check_model();
    step(1'b1, 8'h00, 1'b1, 1'b0, 8'd0, 8'd5);
    check("sat_ffff", 64'(viol_cnt), 64'hFFFF);
    check("sat_late", 64'(viol_late), 64'hFF);
    check_model();
    step(1'b1, 8'h00, 1'b1, 1'b0, 8'd0, 8'd5);
    check("sat_hold", 64'(viol_cnt), 64'hFFFF);
    check_model();
    step(1'b1, 8'h00, 1'b1, 1'b1, 8'd0, 8'd5);
    check("clr_mv", 64'(meas_valid), 64'hFF);
    check("clr_vcnt", 64'(viol_cnt), 64'd0);
    check("clr_late", 64'(viol_late), 64'd0);
    check("clr_early", 64'(viol_early), 64'd0);
    check_model();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
